// File: rtl/seq_shift_unit.sv
// Iterative RV32I shifter (SLL/SRL/SRA): one bit position per clock, start/ready/done handshake.
// Optional rotate-right on op=10 when SEQ_SHIFT_ROTATE_EN is defined; otherwise op=10 acts as SRL.
module seq_shift_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [XLEN-1:0]    data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [XLEN-1:0]    result
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q;
   logic [XLEN-1:0]    result_q;
   logic [XLEN-1:0]    result_d;
   logic [SHAMT_W-1:0] count_q;
   logic [1:0]         op_q;
   logic               done_q;
   logic               ready_q;
   logic               busy_q;

   // Single-position step for the latched operation.
   function automatic logic [XLEN-1:0] shift_step(input logic [1:0] sel, input logic [XLEN-1:0] r);
      logic [XLEN-1:0] s;
      case (sel)
         2'b00:   s = {r[XLEN-2:0], 1'b0};
         2'b11:   s = {r[XLEN-1], r[XLEN-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
         2'b10:   s = {r[0], r[XLEN-1:1]};
`endif
         default: s = {1'b0, r[XLEN-1:1]};
      endcase
      return s;
   endfunction

   assign result_d = shift_step(op_q, result_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         count_q  <= '0;
         op_q     <= 2'b00;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  result_q <= data_in;
                  count_q  <= shamt;
                  op_q     <= op;
                  state_q  <= SHIFT;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= IDLE;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            SHIFT: begin
               // Count reaching zero costs one extra cycle, so shamt=0 still passes through SHIFT.
               if (count_q != '0) begin
                  result_q <= result_d;
                  count_q  <= count_q - SHAMT_W'(1);
               end else begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = ready_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
